channel_frame_deframer: RTL and testbench

CHANNEL_FRAME_DEFRAMER -- requirements
Module: channel_frame_deframer

---
 rtl/channel_pkg.sv | 22 ++
 rtl/frame_xor_accum.sv | 35 +++
 rtl/channel_frame_deframer.sv | 163 ++++++++++++++++
 tb/tb_channel_frame_deframer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/channel_pkg.sv
// ----------------------------------------------------------------------------
// channel_pkg
//   Shared constants and the FSM state type for channel_frame_deframer.
//   Optional feature macro: CHANNEL_FRAME_CHECKSUM_EN adds the CHK state.
//   No ports (package).
// ----------------------------------------------------------------------------
package channel_pkg;

   localparam int NUM_CHANNELS_DEF = 14;
   localparam int DATA_WIDTH_DEF   = 8;
   localparam int CH_IDX_W         = 4;

   typedef enum logic [1:0] {
      ST_HUNT = 2'd0,
      ST_RUN  = 2'd1
`ifdef CHANNEL_FRAME_CHECKSUM_EN
      ,
      ST_CHK  = 2'd2
`endif
   } state_t;

endpackage

// File: rtl/frame_xor_accum.sv
// ----------------------------------------------------------------------------
// frame_xor_accum
//   Running XOR of the samples of one frame, used as the frame checksum.
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     clear        : restart the sum (combined with accumulate, loads data)
//     accumulate   : fold data into the sum this cycle
//     data         : sample to fold in
//     value        : current checksum
// ----------------------------------------------------------------------------
module frame_xor_accum #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         accumulate,
   input  logic [W-1:0] data,
   output logic [W-1:0] value
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= '0;
      end else if (clear && accumulate) begin
         // A new frame's channel 0 starts the sum directly.
         value <= data;
      end else if (clear) begin
         value <= '0;
      end else if (accumulate) begin
         value <= value ^ data;
      end
   end

endmodule

// File: rtl/channel_frame_deframer.sv
// ----------------------------------------------------------------------------
// channel_frame_deframer
//   Demultiplexes an interleaved byte stream into per-channel samples.
//   A byte qualified with frame_start_in is channel 0 of a frame; following
//   bytes carry channels 1..NUM_CHANNELS-1. All outputs are registered.
//   Optional macro CHANNEL_FRAME_CHECKSUM_EN: a trailing XOR checksum byte
//   follows each frame and is verified in the CHK state.
//   Ports:
//     clk, rst_n        : clock, asynchronous active-low reset
//     ena               : global enable; low freezes state and kills strobes
//     data_in           : incoming sample byte
//     data_valid_in     : data_in is valid (byte accepted when ena is high)
//     frame_start_in    : the accepted byte is channel 0 of a new frame
//     sample_out        : demultiplexed sample
//     channel_out       : channel index of sample_out
//     sample_valid_out  : one-cycle strobe, sample_out/channel_out valid
//     frame_done_out    : one-cycle strobe, frame complete
//     frame_error_out   : one-cycle strobe, frame aborted or bad checksum
//     in_sync_out       : high while a frame is in progress
//     state_dbg         : current FSM state, for observation only
//   Handshake: there is no back-pressure; a byte is consumed in every cycle
//   where ena && data_valid_in, and each strobe appears one cycle later.
// ----------------------------------------------------------------------------
module channel_frame_deframer
   import channel_pkg::*;
#(
   parameter int NUM_CHANNELS = NUM_CHANNELS_DEF,
   parameter int DATA_WIDTH   = DATA_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ena,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  data_valid_in,
   input  logic                  frame_start_in,
   output logic [DATA_WIDTH-1:0] sample_out,
   output logic [CH_IDX_W-1:0]   channel_out,
   output logic                  sample_valid_out,
   output logic                  frame_done_out,
   output logic                  frame_error_out,
   output logic                  in_sync_out,
   output logic [1:0]            state_dbg
);

   localparam logic [CH_IDX_W-1:0] LAST_CH = CH_IDX_W'(NUM_CHANNELS - 1);
   localparam logic [CH_IDX_W-1:0] CH_ONE  = CH_IDX_W'(1);

   state_t                state_q, state_d;
   logic [CH_IDX_W-1:0]   cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] sample_d;
   logic [CH_IDX_W-1:0]   channel_d;
   logic                  sv_d, done_d, err_d;
   logic                  acc;

`ifdef CHANNEL_FRAME_CHECKSUM_EN
   logic                  sum_clear, sum_acc;
   logic [DATA_WIDTH-1:0] sum_value;

   frame_xor_accum #(.W(DATA_WIDTH)) u_sum (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (sum_clear),
      .accumulate (sum_acc),
      .data       (data_in),
      .value      (sum_value)
   );
`endif

   assign acc       = ena && data_valid_in;
   assign state_dbg = state_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sample_d  = sample_out;
      channel_d = channel_out;
      sv_d      = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b0;
`ifdef CHANNEL_FRAME_CHECKSUM_EN
      sum_clear = 1'b0;
      sum_acc   = 1'b0;
`endif
      if (acc) begin
         if (frame_start_in) begin
            // Resync from any state; an interrupted frame is flagged.
            sample_d  = data_in;
            channel_d = '0;
            sv_d      = 1'b1;
            err_d     = (state_q != ST_HUNT);
            cnt_d     = CH_ONE;
            state_d   = ST_RUN;
`ifdef CHANNEL_FRAME_CHECKSUM_EN
            sum_clear = 1'b1;
            sum_acc   = 1'b1;
`endif
         end else begin
            case (state_q)
               ST_RUN: begin
                  sample_d  = data_in;
                  channel_d = cnt_q;
                  sv_d      = 1'b1;
`ifdef CHANNEL_FRAME_CHECKSUM_EN
                  sum_acc   = 1'b1;
`endif
                  if (cnt_q == LAST_CH) begin
                     // Counter saturates at the last channel; it is cleared
                     // only when the frame ends.
`ifdef CHANNEL_FRAME_CHECKSUM_EN
                     state_d = ST_CHK;
`else
                     done_d  = 1'b1;
                     state_d = ST_HUNT;
                     cnt_d   = '0;
`endif
                  end else begin
                     cnt_d = cnt_q + CH_ONE;
                  end
               end
`ifdef CHANNEL_FRAME_CHECKSUM_EN
               ST_CHK: begin
                  // Checksum byte is consumed, never emitted as a sample.
                  if (sum_value == data_in) done_d = 1'b1;
                  else                      err_d  = 1'b1;
                  state_d = ST_HUNT;
                  cnt_d   = '0;
               end
`endif
               default: ;  // HUNT: discard until a frame start
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_HUNT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample_out       <= '0;
         channel_out      <= '0;
         sample_valid_out <= 1'b0;
         frame_done_out   <= 1'b0;
         frame_error_out  <= 1'b0;
         in_sync_out      <= 1'b0;
      end else begin
         sample_out       <= sample_d;
         channel_out      <= channel_d;
         sample_valid_out <= sv_d;
         frame_done_out   <= done_d;
         frame_error_out  <= err_d;
         in_sync_out      <= (state_d != ST_HUNT);
      end
   end

endmodule

// File: tb/tb_channel_frame_deframer.sv
// ----------------------------------------------------------------------------
// tb_channel_frame_deframer
//   Directed and random stimulus for channel_frame_deframer, checked every
//   cycle against a frame-level reference model.
// ----------------------------------------------------------------------------
module tb_channel_frame_deframer;

   localparam int N = 14;
   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         ena;
   logic [W-1:0] data_in;
   logic         data_valid_in;
   logic         frame_start_in;
   logic [W-1:0] sample_out;
   logic [3:0]   channel_out;
   logic         sample_valid_out;
   logic         frame_done_out;
   logic         frame_error_out;
   logic         in_sync_out;
   logic [1:0]   state_dbg;

   int checks = 0;
   int errors = 0;

   // Reference model: where we are in the frame, expressed in frame terms.
   // m_phase: 0 = waiting for a frame start, 1 = collecting samples,
   //          2 = expecting checksum byte.
   int           m_phase;
   int           m_next_ch;
   logic [W-1:0] m_xor;
   logic [W-1:0] e_sample;
   logic [3:0]   e_ch;
   logic         e_sv, e_done, e_err;
   string        cur_tag;

   channel_frame_deframer #(.NUM_CHANNELS(N), .DATA_WIDTH(W)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .ena              (ena),
      .data_in          (data_in),
      .data_valid_in    (data_valid_in),
      .frame_start_in   (frame_start_in),
      .sample_out       (sample_out),
      .channel_out      (channel_out),
      .sample_valid_out (sample_valid_out),
      .frame_done_out   (frame_done_out),
      .frame_error_out  (frame_error_out),
      .in_sync_out      (in_sync_out),
      .state_dbg        (state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s/%s observed=%0h expected=%0h", cur_tag, name, obs, exp);
      end
   endtask

   task automatic check_outputs();
      check("sample_out",       32'(sample_out),       32'(e_sample));
      check("channel_out",      32'(channel_out),      32'(e_ch));
      check("sample_valid_out", 32'(sample_valid_out), 32'(e_sv));
      check("frame_done_out",   32'(frame_done_out),   32'(e_done));
      check("frame_error_out",  32'(frame_error_out),  32'(e_err));
      check("in_sync_out",      32'(in_sync_out),      32'(m_phase != 0));
   endtask

   task automatic model_reset();
      m_phase   = 0;
      m_next_ch = 0;
      m_xor     = '0;
      e_sample  = '0;
      e_ch      = '0;
      e_sv      = 1'b0;
      e_done    = 1'b0;
      e_err     = 1'b0;
   endtask

   task automatic emit(input logic [W-1:0] d, input int ch);
      e_sample = d;
      e_ch     = 4'(ch);
      e_sv     = 1'b1;
   endtask

   task automatic model_step(input bit e, input bit v, input bit s, input logic [W-1:0] d);
      e_sv   = 1'b0;
      e_done = 1'b0;
      e_err  = 1'b0;
      if (e && v) begin
         if (s) begin
            e_err     = (m_phase != 0);
            emit(d, 0);
            m_phase   = 1;
            m_next_ch = 1;
            m_xor     = d;
         end else if (m_phase == 1) begin
            emit(d, m_next_ch);
            m_xor = m_xor ^ d;
            if (m_next_ch == N - 1) begin
`ifdef CHANNEL_FRAME_CHECKSUM_EN
               m_phase = 2;
`else
               e_done    = 1'b1;
               m_phase   = 0;
               m_next_ch = 0;
`endif
            end else begin
               m_next_ch++;
            end
         end else if (m_phase == 2) begin
            if (d == m_xor) e_done = 1'b1;
            else            e_err  = 1'b1;
            m_phase   = 0;
            m_next_ch = 0;
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step(input bit e, input bit v, input bit s, input logic [W-1:0] d);
      ena            = e;
      data_valid_in  = v;
      frame_start_in = s;
      data_in        = d;
      model_step(e, v, s, d);
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic send_byte(input logic [W-1:0] d);
      step(1'b1, 1'b1, 1'b0, d);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 8'($urandom));
   endtask

   // Full frame starting at 'base', values base, base+1, ... plus checksum
   // byte when the checksum feature is built in.
   task automatic send_frame(input logic [W-1:0] base);
      logic [W-1:0] x;
      x = '0;
      for (int i = 0; i < N; i++) begin
         step(1'b1, 1'b1, (i == 0), base + 8'(i));
         x = x ^ (base + 8'(i));
      end
`ifdef CHANNEL_FRAME_CHECKSUM_EN
      send_byte(x);
`endif
   endtask

   // Asynchronous reset asserted mid-cycle, checked before any clock edge.
   task automatic pulse_reset();
      data_valid_in  = 1'b0;
      frame_start_in = 1'b0;
      rst_n          = 1'b0;
      #1;
      model_reset();
      cur_tag = "async_reset";
      check_outputs();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      rst_n          = 1'b1;
      ena            = 1'b0;
      data_in        = '0;
      data_valid_in  = 1'b0;
      frame_start_in = 1'b0;
      model_reset();
      #2;
      pulse_reset();

      cur_tag = "idle_after_reset";
      idle(2);

      cur_tag = "full_frame_10";
      send_frame(8'h10);
      idle(1);

      cur_tag = "hunt_discard";
      send_byte(8'hAA);
      send_byte(8'hBB);

      cur_tag = "start_without_valid";
      step(1'b1, 1'b0, 1'b1, 8'h77);
      send_byte(8'h78);

      cur_tag = "resync_abort";
      step(1'b1, 1'b1, 1'b1, 8'h20);
      for (int i = 1; i <= 5; i++) send_byte(8'h20 + 8'(i));
      step(1'b1, 1'b1, 1'b1, 8'h55);
      for (int i = 1; i < N; i++) send_byte(8'h60 + 8'(i));
`ifdef CHANNEL_FRAME_CHECKSUM_EN
      send_byte(8'h00);
`endif
      idle(1);

      cur_tag = "frame_01";
      for (int i = 0; i < N; i++) step(1'b1, 1'b1, (i == 0), 8'(i + 1));
`ifdef CHANNEL_FRAME_CHECKSUM_EN
      send_byte(8'h0F);
      cur_tag = "frame_01_bad_sum";
      for (int i = 0; i < N; i++) step(1'b1, 1'b1, (i == 0), 8'(i + 1));
      send_byte(8'h00);
`endif
      idle(1);

      cur_tag = "reset_mid_frame";
      for (int i = 0; i <= 7; i++) step(1'b1, 1'b1, (i == 0), 8'h30 + 8'(i));
      pulse_reset();
      cur_tag = "frame_after_reset";
      send_frame(8'h40);

      cur_tag = "ena_low_mid_frame";
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, (i == 0), 8'h80 + 8'(i));
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, (i == 1), 8'hEE);
      for (int i = 6; i < N; i++) send_byte(8'h80 + 8'(i));
`ifdef CHANNEL_FRAME_CHECKSUM_EN
      send_byte(8'h80 ^ 8'h81 ^ 8'h82 ^ 8'h83 ^ 8'h84 ^ 8'h85 ^ 8'h86
                ^ 8'h87 ^ 8'h88 ^ 8'h89 ^ 8'h8A ^ 8'h8B ^ 8'h8C ^ 8'h8D);
`endif
      idle(1);

      cur_tag = "random";
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 7) != 0),
              ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 15) == 0),
              8'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
